// File: rtl/tick_mmss_timer.sv
// MM:SS BCD countdown driven by a 1 Hz tick, with expiry flag and upstream tick restart.
// Optional feature: define TICK_MMSS_BLINK_EN to blink the display (Blank) while expired.
module tick_mmss_timer #(
    parameter int MAX_MIN_TENS = 5
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Load,
    input  logic [3:0] LoadMinTens,
    input  logic [3:0] LoadMinOnes,
    input  logic [3:0] LoadSecTens,
    input  logic [3:0] LoadSecOnes,
    input  logic       Start,
    input  logic       Stop,
    output logic [3:0] MinTens,
    output logic [3:0] MinOnes,
    output logic [3:0] SecTens,
    output logic [3:0] SecOnes,
    output logic       Running,
    output logic       Expired,
    output logic       Done,
    output logic       TickRestart,
    output logic       Blank
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] MAX_MT = 4'(MAX_MIN_TENS);

    state_t     state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       running_q, running_d;
    logic       expired_q, expired_d;
    logic       done_q, done_d;
    logic       restart_q, restart_d;
    logic       count_zero;
    logic       tick_act;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign count_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                        (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
    // A tick only acts when no higher-priority control input is present.
    assign tick_act   = Tick && !Load && !Stop && !Start;

    always_comb begin
        state_d    = state_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        done_d     = 1'b0;
        restart_d  = 1'b0;

        if (Load) begin
            min_tens_d = clamp(LoadMinTens, MAX_MT);
            min_ones_d = clamp(LoadMinOnes, 4'd9);
            sec_tens_d = clamp(LoadSecTens, 4'd5);
            sec_ones_d = clamp(LoadSecOnes, 4'd9);
            state_d    = IDLE;
        end else if (Stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end else if (state_q == EXPIRED) begin
                state_d = IDLE;
            end
        end else if (Start) begin
            if ((state_q == IDLE || state_q == PAUSE) && !count_zero) begin
                state_d   = RUN;
                restart_d = 1'b1;
            end
        end else if (tick_act && state_q == RUN && !count_zero) begin
            // BCD borrow chain; RUN is never entered at 00:00 so minutes-tens cannot underflow.
            if (sec_ones_q != 4'd0) begin
                sec_ones_d = sec_ones_q - 4'd1;
            end else begin
                sec_ones_d = 4'd9;
                if (sec_tens_q != 4'd0) begin
                    sec_tens_d = sec_tens_q - 4'd1;
                end else begin
                    sec_tens_d = 4'd5;
                    if (min_ones_q != 4'd0) begin
                        min_ones_d = min_ones_q - 4'd1;
                    end else begin
                        min_ones_d = 4'd9;
                        min_tens_d = min_tens_q - 4'd1;
                    end
                end
            end
            if (min_tens_d == 4'd0 && min_ones_d == 4'd0 &&
                sec_tens_d == 4'd0 && sec_ones_d == 4'd0) begin
                state_d = EXPIRED;
                done_d  = 1'b1;
            end
        end

        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            done_q     <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
            done_q     <= done_d;
            restart_q  <= restart_d;
        end
    end

`ifdef TICK_MMSS_BLINK_EN
    logic blank_q, blank_d;

    // Entry from RUN sees blank_q already 0, so the first tick in EXPIRED drives it to 1.
    always_comb begin
        blank_d = 1'b0;
        if (state_d == EXPIRED) begin
            blank_d = (state_q == EXPIRED && tick_act) ? ~blank_q : blank_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign Blank = blank_q;
`else
    assign Blank = 1'b0;
`endif

    assign MinTens     = min_tens_q;
    assign MinOnes     = min_ones_q;
    assign SecTens     = sec_tens_q;
    assign SecOnes     = sec_ones_q;
    assign Running     = running_q;
    assign Expired     = expired_q;
    assign Done        = done_q;
    assign TickRestart = restart_q;

endmodule

// File: tb/tb_tick_mmss_timer.sv
// Directed vector bench for tick_mmss_timer: one vector per clock, plus reset sequences.
module tb_tick_mmss_timer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Tick = 1'b0, Load = 1'b0, Start = 1'b0, Stop = 1'b0;
    logic [3:0] LoadMinTens = 4'd0, LoadMinOnes = 4'd0, LoadSecTens = 4'd0, LoadSecOnes = 4'd0;
    logic [3:0] MinTens, MinOnes, SecTens, SecOnes;
    logic       Running, Expired, Done, TickRestart, Blank;

`ifdef TICK_MMSS_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    tick_mmss_timer #(.MAX_MIN_TENS(5)) dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .Load(Load),
        .LoadMinTens(LoadMinTens), .LoadMinOnes(LoadMinOnes),
        .LoadSecTens(LoadSecTens), .LoadSecOnes(LoadSecOnes),
        .Start(Start), .Stop(Stop),
        .MinTens(MinTens), .MinOnes(MinOnes), .SecTens(SecTens), .SecOnes(SecOnes),
        .Running(Running), .Expired(Expired), .Done(Done),
        .TickRestart(TickRestart), .Blank(Blank)
    );

    always #10 Clock = ~Clock;

    typedef struct {
        logic        ld;
        logic [15:0] ld_val;
        logic        st;
        logic        sp;
        logic        tk;
        logic [15:0] exp_val;
        logic        run;
        logic        expd;
        logic        done;
        logic        rs;
        logic        blank;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ld, input logic [15:0] ld_val, input logic st,
                       input logic sp, input logic tk, input logic [15:0] exp_val,
                       input logic run, input logic expd, input logic done,
                       input logic rs, input logic blank);
        vec_t v;
        v.ld = ld; v.ld_val = ld_val; v.st = st; v.sp = sp; v.tk = tk;
        v.exp_val = exp_val; v.run = run; v.expd = expd; v.done = done;
        v.rs = rs; v.blank = blank;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {MinTens, MinOnes, SecTens, SecOnes};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_digits"}, digits(), 16'h0000);
        chk({tag, "_flags"}, {11'd0, Running, Expired, Done, TickRestart, Blank}, 16'h0000);
    endtask

    initial begin
        // ld ld_val st sp tk | exp_val run exp done rs blank
        add(1, 16'h0102, 0, 0, 0,  16'h0102, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0,  16'h0102, 1, 0, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0101, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0100, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0059, 1, 0, 0, 0, 0);
        // Load with Tick during RUN aborts the run, tick dropped
        add(1, 16'h0002, 0, 0, 1,  16'h0002, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0,  16'h0002, 1, 0, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0001, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0000, 0, 1, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 0,  16'h0000, 0, 1, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0000, 0, 1, 0, 0, 1);
        add(0, 16'h0000, 0, 0, 1,  16'h0000, 0, 1, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 1,  16'h0000, 0, 1, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0000, 0, 1, 0, 0, 1);
        add(0, 16'h0000, 0, 0, 1,  16'h0000, 0, 1, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0000, 0, 1, 0, 0, 1);
        add(0, 16'h0000, 0, 1, 0,  16'h0000, 0, 0, 0, 0, 0);
        // Start at 00:00 in IDLE is ignored
        add(0, 16'h0000, 1, 0, 0,  16'h0000, 0, 0, 0, 0, 0);
        add(1, 16'hAF7C, 0, 0, 0,  16'h5959, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h5959, 0, 0, 0, 0, 0);
        // Stop beats Tick, pause holds, resume with a dropped tick
        add(1, 16'h0030, 0, 0, 0,  16'h0030, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0,  16'h0030, 1, 0, 0, 1, 0);
        add(0, 16'h0000, 0, 1, 1,  16'h0030, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0030, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 1,  16'h0030, 1, 0, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0029, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 1,  16'h0029, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 1, 0,  16'h0029, 0, 0, 0, 0, 0);
        // Load + Start same cycle: Load wins
        add(1, 16'h0500, 1, 0, 0,  16'h0500, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0,  16'h0500, 1, 0, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0459, 1, 0, 0, 0, 0);
        // Full borrow chain 10:00 -> 09:59
        add(1, 16'h1000, 0, 0, 0,  16'h1000, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0,  16'h1000, 1, 0, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1,  16'h0959, 1, 0, 0, 0, 0);

        // Asynchronous reset assertion with no clock edge
        #2 Reset = 1'b0;
        #3 check_all_zero("reset");
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            Load = vecs[i].ld;
            {LoadMinTens, LoadMinOnes, LoadSecTens, LoadSecOnes} = vecs[i].ld_val;
            Start = vecs[i].st;
            Stop  = vecs[i].sp;
            Tick  = vecs[i].tk;
            @(posedge Clock);
            #1;
            Load = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
            $display("vec %0d ld=%0b st=%0b sp=%0b tk=%0b -> %h run=%0b exp=%0b done=%0b rs=%0b blank=%0b",
                     i, vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].tk, digits(),
                     Running, Expired, Done, TickRestart, Blank);
            chk($sformatf("v%0d_digits", i), digits(), vecs[i].exp_val);
            chk($sformatf("v%0d_running", i), {15'd0, Running}, {15'd0, vecs[i].run});
            chk($sformatf("v%0d_expired", i), {15'd0, Expired}, {15'd0, vecs[i].expd});
            chk($sformatf("v%0d_done", i), {15'd0, Done}, {15'd0, vecs[i].done});
            chk($sformatf("v%0d_restart", i), {15'd0, TickRestart}, {15'd0, vecs[i].rs});
            chk($sformatf("v%0d_blank", i), {15'd0, Blank}, {15'd0, vecs[i].blank & BLINK});
        end

        // Mid-run asynchronous reset at 03:17
        Load = 1'b1;
        {LoadMinTens, LoadMinOnes, LoadSecTens, LoadSecOnes} = 16'h0318;
        @(posedge Clock); #1;
        Load = 1'b0; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0; Tick = 1'b1;
        @(posedge Clock); #1;
        Tick = 1'b0;
        $display("midrun count=%h run=%0b", digits(), Running);
        chk("midrun_digits", digits(), 16'h0317);
        chk("midrun_running", {15'd0, Running}, 16'd1);
        #4 Reset = 1'b0;
        #1;
        $display("midrun reset -> %h run=%0b", digits(), Running);
        check_all_zero("midrun_reset");
        @(negedge Clock);
        Reset = 1'b1;
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        $display("post reset start -> %h run=%0b rs=%0b", digits(), Running, TickRestart);
        check_all_zero("post_reset_start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_mmss_timer.md
# tick_mmss_timer

- Sits directly downstream of `CountdownTimer` and consumes its one-cycle `Pulse` as a 1 Hz `Tick`.
- Holds a minutes:seconds value as four BCD digits and decrements it once per accepted tick while running.
- Flags expiry at 00:00 and requests a restart of the upstream tick generator whenever counting (re)starts, so the first decrement always follows a full period.
- Outputs drive the seven-segment decoders directly.

## Interface

Parameters:
- `MAX_MIN_TENS`, default 5: largest legal minutes-tens digit; larger load values clamp to it.

Ports:
- `Clock` in 1: system clock, 50 MHz.
- `Reset` in 1: asynchronous, active-low reset.
- `Tick` in 1: one-cycle pulse from `CountdownTimer` `Pulse`.
- `Load` in 1: one-cycle pulse; captures the four `Load*` digits.
- `LoadMinTens`, `LoadMinOnes`, `LoadSecTens`, `LoadSecOnes` in 4 each: BCD load digits.
- `Start` in 1: one-cycle pulse; begin or resume counting.
- `Stop` in 1: one-cycle pulse; pause counting, or acknowledge expiry.
- `MinTens`, `MinOnes`, `SecTens`, `SecOnes` out 4 each: current count in BCD.
- `Running` out 1: high in RUN.
- `Expired` out 1: high in EXPIRED.
- `Done` out 1: one-cycle pulse on the transition into EXPIRED.
- `TickRestart` out 1: one-cycle pulse; drives the upstream timer's reset.
- `Blank` out 1: display blank request (see Configuration).

## Operation

- FSM states: IDLE, RUN, PAUSE, EXPIRED. Reset enters IDLE.
- Per-cycle input priority: Load > Stop > Start > Tick. Only the highest-priority asserted input acts; the rest are dropped that cycle.
- Load, from any state:
  - Digits are clamped: ones >9 become 9; `SecTens` >5 becomes 5; `MinTens` >`MAX_MIN_TENS` becomes `MAX_MIN_TENS`.
  - The clamped digits are written and the FSM goes to IDLE.
- Start:
  - From IDLE or PAUSE with count ≠ 00:00: go to RUN and pulse `TickRestart`.
  - With count = 00:00: ignored, state unchanged.
  - In RUN or EXPIRED: ignored.
- Stop:
  - RUN → PAUSE.
  - EXPIRED → IDLE, with the count held at 00:00.
  - In IDLE or PAUSE: ignored.
- Tick:
  - Acts only in RUN; ignored in every other state.
  - Decrement is a BCD borrow chain: `SecOnes` 0→9 borrows from `SecTens`; `SecTens` 0→5 borrows from `MinOnes`; `MinOnes` 0→9 borrows from `MinTens`.
  - Example: 10:00 → 09:59.
- Expiry: when a tick takes the count to 00:00, in the same update:
  - state becomes EXPIRED;
  - `Done` pulses for one cycle;
  - `Expired` goes high and `Running` goes low.
- Count never underflows; in EXPIRED the count stays at 00:00.

## Timing

- All outputs are registered. Reset value of every output is 0; digits read 00:00.
- Tick → digit update: 1 cycle, with the new value visible the cycle after the `Tick` sample edge.
- `Done` and `Expired` rise on the same edge that the digits become 00:00.
- Start → `Running` high: 1 cycle.
- `TickRestart`: high for exactly one cycle, on the same edge that `Running` rises.
  - Upstream counting restarts from the released reset; a `Tick` arriving in the cycle `Start` is accepted is dropped.
- Stop → `Running` low: 1 cycle. A `Tick` in the Stop cycle is not applied.
- Load → digits updated: 1 cycle. A Load during RUN aborts the run; any Tick that cycle is dropped.
- Asynchronous `Reset` assertion mid-run clears all state immediately, independent of `Clock`.

## Configuration

- `TICK_MMSS_BLINK_EN` defined:
  - In EXPIRED, `Blank` toggles on every `Tick`, starting at 1 on the first tick after entry.
  - `Blank` is forced to 0 on exit from EXPIRED and in all other states.
- `TICK_MMSS_BLINK_EN` not defined:
  - `Blank` is constant 0 and no toggle logic is built.
  - All other behaviour is identical.

## Test plan

- Load 01:02, Start, 3 Ticks → after `TickRestart`, digits read 01:01, 01:00, 00:59; `Running`=1 throughout.
- Load 00:02, Start, 2 Ticks → 00:01, then 00:00 with `Done`=1 for one cycle, `Expired`=1, `Running`=0. Further Ticks leave 00:00. Stop → IDLE, `Expired`=0.
- Load with digits A,F,7,C and `MAX_MIN_TENS`=5 → digits read 5,9,5,9. Start at 00:00 → ignored, `TickRestart` stays 0.
- RUN at 00:30; Stop coincident with Tick → PAUSE at 00:30. Start → `TickRestart` pulse; the next Tick gives 00:29.
- Load 05:00 and Start in the same cycle → IDLE at 05:00 with no `TickRestart`. `Reset` low mid-run at 03:17 → immediate 00:00, all outputs 0.
- With `TICK_MMSS_BLINK_EN`: in EXPIRED, 4 Ticks give `Blank` = 1,0,1,0; Stop forces it to 0. Without the macro, `Blank` stays 0 throughout.
